// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and constants for the framebuffer arbiter slice.
// Optional statistics counters are enabled with VGACPU_FB_ARB_STATS_EN.
package vgacpu_fb_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 3;

    // Which requester a RAM read in flight belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    // One-entry CPU write buffer occupancy.
    typedef enum logic {
        WBUF_EMPTY = 1'b0,
        WBUF_FULL  = 1'b1
    } fb_wbuf_state_t;

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_write_buffer.sv
// One-entry CPU store buffer. A store is captured on accept and leaves
// on drain; accept and drain together reload the entry and stay FULL.
module fb_write_buffer
    import vgacpu_fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              drain,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data
);

    fb_wbuf_state_t state, state_next;

    // State register: reset clears any pending store.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WBUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a new accept always wins over a drain.
    always_comb begin
        state_next = state;
        case (state)
            WBUF_EMPTY: begin
                if (accept) state_next = WBUF_FULL;
                else        state_next = WBUF_EMPTY;
            end
            WBUF_FULL: begin
                if (accept)     state_next = WBUF_FULL;
                else if (drain) state_next = WBUF_EMPTY;
                else            state_next = WBUF_FULL;
            end
            default: state_next = WBUF_EMPTY;
        endcase
    end

    // Output decode of the occupancy.
    always_comb begin
        full = (state == WBUF_FULL);
    end

    // Payload capture on every accepted store.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_addr <= '0;
            buf_data <= '0;
        end else if (accept) begin
            buf_addr <= wr_addr;
            buf_data <= wr_data;
        end else begin
            buf_addr <= buf_addr;
            buf_data <= buf_data;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: VGA scanout has absolute priority, then the
// buffered CPU store, then CPU reads. Reads return after 2 cycles.
// Defining VGACPU_FB_ARB_STATS_EN builds the stall/VGA usage counters.
module vga_fb_arbiter
    import vgacpu_fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rdata_valid,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rdata_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       vga_cycles
);

    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              wr_accept;
    logic              rd_accept;
    logic              drain;
    owner_t            issue_owner;
    owner_t            own_p1;
    owner_t            own_p2;

    fb_write_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk      (clk),
        .rst      (rst),
        .accept   (wr_accept),
        .drain    (drain),
        .wr_addr  (cpu_addr),
        .wr_data  (cpu_wdata),
        .full     (buf_full),
        .buf_addr (buf_addr),
        .buf_data (buf_data)
    );

    // CPU handshake: reads wait for a free port and an empty buffer so a
    // read can never overtake a store; writes only need somewhere to land.
    always_comb begin
        cpu_ready = 1'b0;
        if (rst) begin
            cpu_ready = 1'b0;
        end else if (cpu_valid) begin
            if (cpu_we) cpu_ready = !buf_full || !vga_req;
            else        cpu_ready = !vga_req && !buf_full;
        end else begin
            cpu_ready = 1'b0;
        end
        wr_accept = cpu_valid && cpu_we && cpu_ready;
        rd_accept = cpu_valid && !cpu_we && cpu_ready;
        drain     = !rst && buf_full && !vga_req;
    end

    // RAM port owner selection in strict priority order.
    always_comb begin
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        issue_owner = OWN_NONE;
        if (rst) begin
            issue_owner = OWN_NONE;
        end else if (vga_req) begin
            ram_en      = 1'b1;
            ram_addr    = vga_addr;
            issue_owner = OWN_VGA;
        end else if (buf_full) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = buf_addr;
            ram_wdata = buf_data;
        end else if (rd_accept) begin
            ram_en      = 1'b1;
            ram_addr    = cpu_addr;
            issue_owner = OWN_CPU;
        end else begin
            issue_owner = OWN_NONE;
        end
    end

    // Owner pipeline: stage 1 lines up with ram_rdata, stage 2 with outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            own_p1 <= OWN_NONE;
            own_p2 <= OWN_NONE;
        end else begin
            own_p1 <= issue_owner;
            own_p2 <= own_p1;
        end
    end

    // Return data capture; each output holds until its next read returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_rdata <= '0;
            cpu_rdata <= '0;
        end else begin
            if (own_p1 == OWN_VGA) vga_rdata <= ram_rdata;
            else                   vga_rdata <= vga_rdata;
            if (own_p1 == OWN_CPU) cpu_rdata <= ram_rdata;
            else                   cpu_rdata <= cpu_rdata;
        end
    end

    assign vga_rdata_valid = (own_p2 == OWN_VGA);
    assign cpu_rdata_valid = (own_p2 == OWN_CPU);

`ifdef VGACPU_FB_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] vga_cnt;

    // Saturating usage counters for performance analysis.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            vga_cnt   <= 16'd0;
        end else begin
            if (cpu_valid && !cpu_ready) stall_cnt <= sat_inc16(stall_cnt);
            else                         stall_cnt <= stall_cnt;
            if (vga_req) vga_cnt <= sat_inc16(vga_cnt);
            else         vga_cnt <= vga_cnt;
        end
    end

    assign stall_cycles = stall_cnt;
    assign vga_cycles   = vga_cnt;
`else
    assign stall_cycles = 16'd0;
    assign vga_cycles   = 16'd0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_vga_fb_arbiter;

    localparam int AW = 15;
    localparam int DW = 3;
`ifdef VGACPU_FB_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_rdata;
    logic          vga_rdata_valid;
    logic          cpu_valid = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rdata_valid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [15:0]   stall_cycles;
    logic [15:0]   vga_cycles;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .vga_req         (vga_req),
        .vga_addr        (vga_addr),
        .vga_rdata       (vga_rdata),
        .vga_rdata_valid (vga_rdata_valid),
        .cpu_valid       (cpu_valid),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ready       (cpu_ready),
        .cpu_rdata       (cpu_rdata),
        .cpu_rdata_valid (cpu_rdata_valid),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .stall_cycles    (stall_cycles),
        .vga_cycles      (vga_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] init_val(input int i);
        if (i == 16) return 3'b101;
        return 3'(i * 7 + (i >> 4));
    endfunction

    // Single-port RAM: one-cycle registered read.
    logic [DW-1:0] mem [0:32767];
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] <= init_val(i);
        ram_rdata <= 3'd0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we) mem[ram_addr] <= ram_wdata;
                else        ram_rdata     <= mem[ram_addr];
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int           due;
        int           who;   // 1 = VGA, 2 = CPU
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] shadow [0:32767];
    int            cyc = 0;
    bit            mb_full = 1'b0;
    logic [AW-1:0] mb_addr = '0;
    logic [DW-1:0] mb_data = '0;
    logic [DW-1:0] e_vdata = '0;
    logic [DW-1:0] e_cdata = '0;
    int            e_stall = 0;
    int            e_vcnt  = 0;
    bit            m_ev, m_ec, m_ready, m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;

    // Compare process: once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 32768; i++) shadow[i] = init_val(i);
        end
        // Returns scheduled for this cycle.
        m_ev = 1'b0;
        m_ec = 1'b0;
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            if (rq[0].due == cyc) begin
                if (rq[0].who == 1) begin m_ev = 1'b1; e_vdata = rq[0].data; end
                else                begin m_ec = 1'b1; e_cdata = rq[0].data; end
            end
            void'(rq.pop_front());
        end
        check("vga_rdata_valid", 32'(vga_rdata_valid), 32'(m_ev));
        check("vga_rdata", 32'(vga_rdata), 32'(e_vdata));
        check("cpu_rdata_valid", 32'(cpu_rdata_valid), 32'(m_ec));
        check("cpu_rdata", 32'(cpu_rdata), 32'(e_cdata));
        check("stall_cycles", 32'(stall_cycles), STATS ? 32'(e_stall) : 32'd0);
        check("vga_cycles", 32'(vga_cycles), STATS ? 32'(e_vcnt) : 32'd0);

        // What the port and handshake must do this cycle.
        m_ready = 1'b0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
        if (!rst) begin
            if (cpu_valid) m_ready = cpu_we ? (!mb_full || !vga_req) : (!vga_req && !mb_full);
            if (vga_req) begin
                m_en = 1'b1; m_addr = vga_addr;
                rq.push_back('{due: cyc + 2, who: 1, data: shadow[vga_addr]});
            end else if (mb_full) begin
                m_en = 1'b1; m_we = 1'b1; m_addr = mb_addr; m_wd = mb_data;
            end else if (cpu_valid && !cpu_we && m_ready) begin
                m_en = 1'b1; m_addr = cpu_addr;
                rq.push_back('{due: cyc + 2, who: 2, data: shadow[cpu_addr]});
            end
        end
        check("cpu_ready", 32'(cpu_ready), 32'(m_ready));
        check("ram_en", 32'(ram_en), 32'(m_en));
        check("ram_we", 32'(ram_we), 32'(m_we));
        if (m_en) check("ram_addr", 32'(ram_addr), 32'(m_addr));
        if (m_we) check("ram_wdata", 32'(ram_wdata), 32'(m_wd));

        // Advance the model to the next cycle.
        if (rst) begin
            mb_full = 1'b0;
            rq.delete();
            e_vdata = '0; e_cdata = '0;
            e_stall = 0;  e_vcnt = 0;
        end else begin
            if (m_we) shadow[mb_addr] = mb_data;
            if (cpu_valid && cpu_we && m_ready) begin
                mb_full = 1'b1; mb_addr = cpu_addr; mb_data = cpu_wdata;
            end else if (m_we) begin
                mb_full = 1'b0;
            end
            if (cpu_valid && !m_ready) e_stall = (e_stall < 65535) ? e_stall + 1 : 65535;
            if (vga_req)               e_vcnt  = (e_vcnt  < 65535) ? e_vcnt  + 1 : 65535;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit vr, input int va, input bit cv, input bit cw,
                          input int ca, input int cd);
        vga_req   = vr;
        vga_addr  = AW'(va);
        cpu_valid = cv;
        cpu_we    = cw;
        cpu_addr  = AW'(ca);
        cpu_wdata = DW'(cd);
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    int vp, cp;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        #2;
        check("reset vga_rdata_valid", 32'(vga_rdata_valid), 32'd0);
        check("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("reset ram_en", 32'(ram_en), 32'd0);
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);
        tick();

        // VGA read only.
        set_in(1'b1, 16'h0010, 1'b0, 1'b0, 0, 0); #2;
        check("vga issue ram_en", 32'(ram_en), 32'd1);
        check("vga issue ram_addr", 32'(ram_addr), 32'h10);
        tick();
        idle(0); #2;
        check("vga N+1 valid", 32'(vga_rdata_valid), 32'd0);
        tick(); #2;
        check("vga N+2 valid", 32'(vga_rdata_valid), 32'd1);
        check("vga N+2 data", 32'(vga_rdata), 32'b101);
        check("vga N+2 cpu valid", 32'(cpu_rdata_valid), 32'd0);
        idle(3);

        // Contended write.
        set_in(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0100, 3); #2;
        check("cw accept", 32'(cpu_ready), 32'd1);
        check("cw no write at accept", 32'(ram_we), 32'd0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 16'h0020 + i, 1'b1, 1'b1, 16'h0101, 7); #2;
            check("cw second write stalled", 32'(cpu_ready), 32'd0);
            tick();
        end
        idle(0); #2;
        check("cw drain we", 32'(ram_we), 32'd1);
        check("cw drain addr", 32'(ram_addr), 32'h100);
        check("cw drain data", 32'(ram_wdata), 32'b011);
        idle(4);

        // Read behind write.
        set_in(1'b0, 0, 1'b1, 1'b1, 16'h0200, 6); #2;
        check("rbw write accept", 32'(cpu_ready), 32'd1);
        tick();
        set_in(1'b0, 0, 1'b1, 1'b0, 16'h0200, 0); #2;
        check("rbw read stalls", 32'(cpu_ready), 32'd0);
        check("rbw drain", 32'(ram_we), 32'd1);
        tick(); #2;
        check("rbw read accepted", 32'(cpu_ready), 32'd1);
        check("rbw read issued", 32'(ram_en && !ram_we), 32'd1);
        tick();
        idle(1); #2;
        check("rbw valid", 32'(cpu_rdata_valid), 32'd1);
        check("rbw data", 32'(cpu_rdata), 32'b110);
        idle(3);

        // Back-to-back alternating reads.
        vp = 0; cp = 0;
        for (int i = 0; i < 11; i++) begin
            if (i >= 8)        set_in(1'b0, 0, 1'b0, 1'b0, 0, 0);
            else if (i % 2)    set_in(1'b1, 16'h0300 + i, 1'b0, 1'b0, 0, 0);
            else               set_in(1'b0, 0, 1'b1, 1'b0, 16'h0400 + i, 0);
            #2;
            if (vga_rdata_valid) vp++;
            if (cpu_rdata_valid) cp++;
            tick();
        end
        check("b2b vga pulses", 32'(vp), 32'd4);
        check("b2b cpu pulses", 32'(cp), 32'd4);
        idle(2);

        // Reset with a read in flight, then with a store buffered.
        set_in(1'b0, 0, 1'b1, 1'b0, 16'h0500, 0);
        tick();
        idle(0); rst = 1'b1;
        tick();
        rst = 1'b0; #2;
        check("rst no cpu valid", 32'(cpu_rdata_valid), 32'd0);
        check("rst cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst vga_rdata", 32'(vga_rdata), 32'd0);
        check("rst ram_en", 32'(ram_en), 32'd0);
        check("rst cpu_ready", 32'(cpu_ready), 32'd0);
        tick();
        set_in(1'b1, 16'h0040, 1'b1, 1'b1, 16'h0600, 5);
        tick();
        set_in(1'b1, 16'h0041, 1'b0, 1'b0, 0, 0); rst = 1'b1;
        tick();
        rst = 1'b0; idle(0); #2;
        check("rst store discarded", 32'(ram_en), 32'd0);
        idle(3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            set_in($urandom_range(0, 99) < 45, $urandom_range(0, 31),
                   $urandom_range(0, 99) < 60, $urandom_range(0, 1),
                   $urandom_range(0, 31), $urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        idle(4);

`ifdef VGACPU_FB_ARB_STATS_EN
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, i, 1'b1, 1'b0, 16'h0010, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, i, 1'b0, 1'b0, 0, 0);
            tick();
        end
        idle(0); #2;
        check("stats stall 5", 32'(stall_cycles), 32'd5);
        check("stats vga 7", 32'(vga_cycles), 32'd7);
        tick();
        set_in(1'b1, 16'h0011, 1'b1, 1'b0, 16'h0012, 0);
        for (int i = 0; i < 70000; i++) tick();
        idle(0); #2;
        check("stats stall saturates", 32'(stall_cycles), 32'hFFFF);
        check("stats vga saturates", 32'(vga_cycles), 32'hFFFF);
        idle(3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
